// File: rtl/cpu_bus_initiator_pkg.sv
// Shared types and constants for the NES/Famicom CPU-side bus initiator.
// Contents: bus phase enum, latched request struct, address-space constants,
// and a helper that tells whether an address decodes to cartridge ROM space.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned CPU_ADDR_W    = 15;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ROM_SPACE_BIT = 15;

  localparam logic [ADDR_W-1:0] IDLE_ADDR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } phase_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;     // 1 = read, 0 = write
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic logic is_rom(input logic [ADDR_W-1:0] addr);
    return addr[ROM_SPACE_BIT];
  endfunction

endpackage

// File: rtl/cpu_bus_initiator_if.sv
// Host request/response and cartridge CPU-bus signals of the bus initiator.
// master: the initiator (drives req_ready, rsp_*, M2, /ROMSEL, R/W, A, data, irq_pending).
// slave : the host + cartridge environment facing it.
interface cpu_bus_initiator_if;
  import cpu_bus_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_rw;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  m2;
  logic                  romsel;
  logic                  cpu_rw;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_data_out;
  logic                  cpu_data_oe;
  logic [DATA_W-1:0]     cpu_data_in;
  logic                  irq_n;
  logic                  irq_pending;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_pending
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_pending
  );

endinterface

// File: rtl/cpu_bus_initiator_sync_2ff.sv
// Two-flop synchroniser for an asynchronous active-low level; both flops reset to 1.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronised output).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/cpu_bus_initiator.sv
// Console-side CPU bus master for a Famicom/NES cartridge: turns host
// valid/ready requests into M2 bus cycles (LOW half then HIGH half, HALF_PERIOD
// clk each), returns read data and a synchronised cartridge IRQ.
// Ports: clk, rst_n (async active-low), bus (cpu_bus_initiator_if.master):
//   host side req_valid/req_ready/req_addr/req_rw/req_wdata, rsp_valid/rsp_rdata;
//   cartridge side m2, romsel, cpu_rw, cpu_addr, cpu_data_out/oe, cpu_data_in,
//   irq_n in, irq_pending out.
// Build option: CPU_BUS_M2_FREE_RUN_EN keeps M2 running with dummy reads at
// IDLE_ADDR instead of parking in IDLE when the host is quiet.
module cpu_bus_initiator
  import cpu_bus_pkg::*;
#(
  parameter int unsigned       HALF_PERIOD = 6,
  parameter int unsigned       WR_DELAY    = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  cpu_bus_initiator_if.master bus
);

  localparam int unsigned     CNT_W    = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] WR_AT    = CNT_W'(WR_DELAY);
`ifdef CPU_BUS_M2_FREE_RUN_EN
  localparam bit FREE_RUN = 1'b1;
`else
  localparam bit FREE_RUN = 1'b0;
`endif

  phase_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  bus_req_t              req_q, req_d;
  logic                  active_q, active_d;   // current cycle belongs to the host
  logic                  m2_q, m2_d;
  logic                  romsel_q, romsel_d;
  logic                  cpu_rw_q, cpu_rw_d;
  logic [CPU_ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  oe_q, oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  irq_pending_q;
  logic                  irq_sync;
  logic                  boundary_c, ready_c, accept_c;

  // Next cycle / next output values; outputs are derived from the next state so they leave flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    active_d    = active_q;
    cpu_rw_d    = cpu_rw_q;
    cpu_addr_d  = cpu_addr_q;
    data_out_d  = data_out_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    boundary_c = (state_q == HIGH) && (cnt_q == CNT_LAST);
    ready_c    = boundary_c || (state_q == IDLE);
    accept_c   = bus.req_valid && ready_c;

    // Completion of a host cycle: read data is sampled on the last clk of M2 high.
    if (boundary_c && active_q) begin
      rsp_valid_d = 1'b1;
      if (req_q.rw) rsp_rdata_d = bus.cpu_data_in;
    end

    unique case (state_q)
      IDLE: ;
      LOW: begin
        // Only the post-reset LOW can be non-host; without free-run it parks at once.
        if (!FREE_RUN && !active_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        else if (!accept_c && FREE_RUN) begin
          state_d    = LOW;
          cnt_d      = '0;
          req_d      = '{addr: IDLE_ADDR, rw: 1'b1, wdata: '0};
          active_d   = 1'b0;
          cpu_addr_d = IDLE_ADDR[CPU_ADDR_W-1:0];
          cpu_rw_d   = 1'b1;
        end else if (!accept_c) begin
          state_d  = IDLE;
          active_d = 1'b0;
          cpu_rw_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepted request starts a fresh bus cycle on the next clk.
    if (accept_c) begin
      state_d    = LOW;
      cnt_d      = '0;
      req_d      = '{addr: bus.req_addr, rw: bus.req_rw, wdata: bus.req_wdata};
      active_d   = 1'b1;
      cpu_addr_d = bus.req_addr[CPU_ADDR_W-1:0];
      cpu_rw_d   = bus.req_rw;
    end

    m2_d     = (state_d == HIGH);
    romsel_d = ~(is_rom(req_d.addr) && (state_d == HIGH));
    oe_d     = (state_d == HIGH) && (cnt_d >= WR_AT) && !req_d.rw && active_d;
    if (oe_d) data_out_d = req_d.wdata;
  end

  // All state and pad-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOW;
      cnt_q         <= '0;
      req_q         <= '{addr: IDLE_ADDR, rw: 1'b1, wdata: '0};
      active_q      <= 1'b0;
      m2_q          <= 1'b0;
      romsel_q      <= 1'b1;
      cpu_rw_q      <= 1'b1;
      cpu_addr_q    <= '0;
      data_out_q    <= '0;
      oe_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      active_q      <= active_d;
      m2_q          <= m2_d;
      romsel_q      <= romsel_d;
      cpu_rw_q      <= cpu_rw_d;
      cpu_addr_q    <= cpu_addr_d;
      data_out_q    <= data_out_d;
      oe_q          <= oe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      irq_pending_q <= ~irq_sync;
    end
  end

  sync_2ff u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.irq_n),
    .q_o   (irq_sync)
  );

  assign bus.req_ready    = ready_c;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.m2           = m2_q;
  assign bus.romsel       = romsel_q;
  assign bus.cpu_rw       = cpu_rw_q;
  assign bus.cpu_addr     = cpu_addr_q;
  assign bus.cpu_data_out = data_out_q;
  assign bus.cpu_data_oe  = oe_q;
  assign bus.irq_pending  = irq_pending_q;

endmodule
